panda_dmem_arbiter: RTL and testbench
=====================================

Name: panda_dmem_arbiter

Overview:
Two-port arbiter that shares the single-port data RAM (panda_ram, 32-bit, byte write enables) between the core load-store path (port 0) and an external master (port 1: program loader / debug / DMA).
- Sits between the datapath data interface, the external bus, and the RAM instance.
- Uses a req/gnt/rvalid handshake per port: one access per cycle, pipelined, with a one-cycle response.
- Tracks the owner of the in-flight response so read data is returned to the correct port.

Parameters:
- DataMemDepth, 32, RAM depth in 32-bit words (power of two, >= 2).
- RoundRobin, 1'b1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous reset, active-high.
- p0_req_i  in  1  port 0 request.
- p0_we_i  in  4  port 0 byte write enables; 0 = read.
- p0_addr_i  in  32  port 0 byte address.
- p0_wdata_i  in  32  port 0 write data.
- p0_gnt_o  out  1  port 0 request accepted this cycle.
- p0_rvalid_o  out  1  port 0 response valid (one cycle after gnt).
- p0_rdata_o  out  32  port 0 read data.
- p1_req_i, p1_we_i, p1_addr_i, p1_wdata_i, p1_gnt_o, p1_rvalid_o, p1_rdata_o: same as port 0, for port 1.
- ram_ce_o  out  1  RAM chip enable.
- ram_we_o  out  4  RAM byte write enables.
- ram_addr_o  out  $clog2(DataMemDepth)  RAM word address.
- ram_wdata_o  out  32  RAM write data.
- ram_rdata_i  in  32  RAM read data, valid one cycle after the access.

Behaviour:
- Reset: all outputs 0 while rst_i is high. After reset: rr_ptr = port 0, resp_valid_q = 0, resp_owner_q = 0.
- Grant (combinational, same cycle as req):
  - Only one requester: it is granted.
  - Both requesting, RoundRobin = 1: the port selected by rr_ptr is granted. rr_ptr then moves to the other port; it moves only when a grant occurs while both ports are requesting.
  - Both requesting, RoundRobin = 0: port 0 is always granted.
  - gnt is never asserted while rst_i is high.
- RAM drive:
  - ram_ce_o = any grant.
  - ram_we_o, ram_wdata_o and ram_addr_o are taken from the granted port. Address is addr[$clog2(DataMemDepth)+1:2]; the two LSBs and upper bits are ignored (no fault).
  - With no grant, ram_we_o = 0 and the address/data outputs hold the port 0 values (don't care).
- Response pipeline:
  - resp_valid_q <= any grant; resp_owner_q <= granted port.
  - Next cycle, pX_rvalid_o = resp_valid_q & (owner == X). Writes also get an rvalid (ack).
  - pX_rdata_o = ram_rdata_i when the port owns the response, else 0.
- Throughput and latency: one grant per cycle; back-to-back grants to the same or different ports are allowed with no bubble. Latency from req to rvalid is 1 cycle when uncontended.
- Requester obligation: req, addr, we and wdata are held stable until gnt. The arbiter does not latch requests; a request dropped before gnt is lost.
- Reset mid-operation: an in-flight response is discarded and no rvalid is issued. Reset takes priority over any simultaneous req.
- Write/read of the same address in consecutive cycles: the RAM read-after-write order is preserved, because accesses are serialized by grant order.

Optional Feature:
- Macro: PANDA_DMEM_ARB_PERF_EN.
- Defined: adds outputs p0_grant_cnt_o, p1_grant_cnt_o and stall_cnt_o (32 bits each, saturating at 0xFFFFFFFF, cleared by rst_i).
  - The grant counters increment per grant to their port.
  - stall_cnt_o increments each cycle in which one port requests and is not granted; if both ports are stalled in the same cycle it increments once.
- Undefined: these ports and counters do not exist; the behaviour is otherwise identical.

Decomposition:
- panda_pkg gains:
  - typedef enum logic {DMEM_PORT_CORE = 1'b0, DMEM_PORT_EXT = 1'b1} dmem_port_e, used for rr_ptr and resp_owner_q.
  - localparam DMEM_WIDTH = 32.
- Sub-module panda_rr_arbiter2: two-way request vector in, one-hot grant out, with rr pointer register and RoundRobin parameter. Reusable for a later instruction-memory arbiter.

Test Plan:
1. Reset behaviour: hold rst_i for 3 cycles with p0_req = p1_req = 1 -> all gnt, rvalid and ram_ce stay 0. After release, the first cycle grants p0 and drives ram_ce = 1.
2. Single port, write then read: p0 writes addr 0x0000_0010, we = 4'hF, data 0xDEADBEEF; next cycle p0 reads 0x10.
   - Expect gnt in both cycles and rvalid in each following cycle.
   - Read returns 0xDEADBEEF on p0_rdata_o; p1_rvalid_o stays 0.
3. Contention, RoundRobin = 1: both ports hold req for 4 cycles, each reading a distinct address.
   - Expect grant order p0, p1, p0, p1.
   - Each rvalid goes only to the owner of the previous cycle, with the correct data.
4. Contention, RoundRobin = 0: both ports hold req for 3 cycles -> p0 is granted every cycle and p1_gnt_o stays 0. p1 is granted in the first cycle after p0 drops req.
5. Byte write and address wrap: p1 writes we = 4'b0010, data 0x0000_AB00 to byte address 0x0000_0084 (DataMemDepth = 32, so word 1); then p0 reads 0x0000_0004.
   - Read returns the old word with byte 1 = 0xAB.
6. Reset mid-flight: p0 read is granted; rst_i is asserted the next cycle -> p0_rvalid_o = 0 in that cycle. With PANDA_DMEM_ARB_PERF_EN defined, all counters read 0 after reset.

Source files
------------

// File: rtl/panda_pkg.sv
// Shared types and constants for the panda data-memory subsystem.
// Pure declarations, no logic or latency.
// Holds the port identifiers used for arbitration and response tracking.
package panda_pkg;

  localparam int DMEM_WIDTH = 32;

  // Port identity, used for the round-robin pointer and the response owner.
  typedef enum logic {
    DMEM_PORT_CORE = 1'b0,
    DMEM_PORT_EXT  = 1'b1
  } dmem_port_e;

  // The port that is not p; a two-way round-robin simply alternates.
  function automatic dmem_port_e dmem_other_port(input dmem_port_e p);
    return (p == DMEM_PORT_CORE) ? DMEM_PORT_EXT : DMEM_PORT_CORE;
  endfunction

endpackage

// File: rtl/panda_rr_arbiter2.sv
// Two-way arbiter: request vector in, one-hot grant out.
// Latency: grant is combinational in the request cycle.
// Backpressure: losers are simply not granted; the pointer only moves on contention.
module panda_rr_arbiter2
  import panda_pkg::*;
#(
  parameter bit RoundRobin = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o
);

  dmem_port_e rr_ptr_q, rr_ptr_d;

  // Pick the winner; the pointer advances past the winner only when both asked.
  always_comb begin
    gnt_o    = 2'b00;
    rr_ptr_d = rr_ptr_q;
    if (!rst_i) begin
      unique case (req_i)
        2'b01: gnt_o = 2'b01;
        2'b10: gnt_o = 2'b10;
        2'b11: begin
          if (RoundRobin && (rr_ptr_q == DMEM_PORT_EXT)) begin
            gnt_o    = 2'b10;
            rr_ptr_d = dmem_other_port(DMEM_PORT_EXT);
          end else begin
            gnt_o    = 2'b01;
            rr_ptr_d = dmem_other_port(DMEM_PORT_CORE);
          end
        end
        default: gnt_o = 2'b00;
      endcase
    end
  end

  // Pointer register; reset favours the core port.
  always_ff @(posedge clk_i) begin
    if (rst_i) rr_ptr_q <= DMEM_PORT_CORE;
    else       rr_ptr_q <= rr_ptr_d;
  end

endmodule

// File: rtl/panda_dmem_arbiter.sv
// Shares the single-port data RAM between the core (port 0) and an external master (port 1).
// Latency: grant in the request cycle, rvalid/rdata one cycle after grant, no bubbles.
// Backpressure: a port that is not granted must hold its request; nothing is latched.
// Optional grant/stall counters are built when PANDA_DMEM_ARB_PERF_EN is defined.
module panda_dmem_arbiter
  import panda_pkg::*;
#(
  parameter int DataMemDepth = 32,
  parameter bit RoundRobin   = 1'b1
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            p0_req_i,
  input  logic [3:0]                      p0_we_i,
  input  logic [31:0]                     p0_addr_i,
  input  logic [DMEM_WIDTH-1:0]           p0_wdata_i,
  output logic                            p0_gnt_o,
  output logic                            p0_rvalid_o,
  output logic [DMEM_WIDTH-1:0]           p0_rdata_o,
  input  logic                            p1_req_i,
  input  logic [3:0]                      p1_we_i,
  input  logic [31:0]                     p1_addr_i,
  input  logic [DMEM_WIDTH-1:0]           p1_wdata_i,
  output logic                            p1_gnt_o,
  output logic                            p1_rvalid_o,
  output logic [DMEM_WIDTH-1:0]           p1_rdata_o,
`ifdef PANDA_DMEM_ARB_PERF_EN
  output logic [31:0]                     p0_grant_cnt_o,
  output logic [31:0]                     p1_grant_cnt_o,
  output logic [31:0]                     stall_cnt_o,
`endif
  output logic                            ram_ce_o,
  output logic [3:0]                      ram_we_o,
  output logic [$clog2(DataMemDepth)-1:0] ram_addr_o,
  output logic [DMEM_WIDTH-1:0]           ram_wdata_o,
  input  logic [DMEM_WIDTH-1:0]           ram_rdata_i
);

  localparam int AW = $clog2(DataMemDepth);

  logic [1:0] gnt;
  logic       resp_valid_q;
  dmem_port_e resp_owner_q;

  panda_rr_arbiter2 #(.RoundRobin(RoundRobin)) u_arb (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .req_i ({p1_req_i, p0_req_i}),
    .gnt_o (gnt)
  );

  assign p0_gnt_o = gnt[0];
  assign p1_gnt_o = gnt[1];

  // RAM mux: granted port drives the RAM; idle cycles show port 0 with no write.
  always_comb begin
    ram_ce_o    = |gnt;
    ram_we_o    = 4'h0;
    ram_addr_o  = '0;
    ram_wdata_o = '0;
    if (!rst_i) begin
      if (gnt[1]) begin
        ram_we_o    = p1_we_i;
        ram_addr_o  = p1_addr_i[AW+1:2];
        ram_wdata_o = p1_wdata_i;
      end else begin
        ram_we_o    = gnt[0] ? p0_we_i : 4'h0;
        ram_addr_o  = p0_addr_i[AW+1:2];
        ram_wdata_o = p0_wdata_i;
      end
    end
  end

  // Remember who owns the access now in the RAM so its data returns to them.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      resp_valid_q <= 1'b0;
      resp_owner_q <= DMEM_PORT_CORE;
    end else begin
      resp_valid_q <= |gnt;
      resp_owner_q <= gnt[1] ? DMEM_PORT_EXT : DMEM_PORT_CORE;
    end
  end

  // Reset kills an in-flight response immediately, not one cycle later.
  assign p0_rvalid_o = !rst_i && resp_valid_q && (resp_owner_q == DMEM_PORT_CORE);
  assign p1_rvalid_o = !rst_i && resp_valid_q && (resp_owner_q == DMEM_PORT_EXT);
  assign p0_rdata_o  = p0_rvalid_o ? ram_rdata_i : '0;
  assign p1_rdata_o  = p1_rvalid_o ? ram_rdata_i : '0;

  // Byte offset and out-of-range upper bits are ignored by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{p0_addr_i[31:AW+2], p0_addr_i[1:0],
                              p1_addr_i[31:AW+2], p1_addr_i[1:0]};

`ifdef PANDA_DMEM_ARB_PERF_EN
  logic stall;
  assign stall = (p0_req_i && !gnt[0]) || (p1_req_i && !gnt[1]);

  // Saturating grant and stall counters; a double stall counts once.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      p0_grant_cnt_o <= '0;
      p1_grant_cnt_o <= '0;
      stall_cnt_o    <= '0;
    end else begin
      if (gnt[0] && (p0_grant_cnt_o != 32'hFFFF_FFFF)) p0_grant_cnt_o <= p0_grant_cnt_o + 32'd1;
      if (gnt[1] && (p1_grant_cnt_o != 32'hFFFF_FFFF)) p1_grant_cnt_o <= p1_grant_cnt_o + 32'd1;
      if (stall  && (stall_cnt_o    != 32'hFFFF_FFFF)) stall_cnt_o    <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_panda_dmem_arbiter.sv
// Directed bench: round-robin instance (a_*) and fixed-priority instance (f_*) share stimulus,
// each backed by its own behavioural RAM with one-cycle read latency.
module tb_panda_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        ram_init;
  logic        p0_req, p1_req;
  logic [3:0]  p0_we, p1_we;
  logic [31:0] p0_addr, p1_addr, p0_wdata, p1_wdata;

  logic        a_p0_gnt, a_p0_rvalid, a_p1_gnt, a_p1_rvalid, a_ram_ce;
  logic [31:0] a_p0_rdata, a_p1_rdata, a_ram_wdata, a_ram_rdata;
  logic [3:0]  a_ram_we;
  logic [4:0]  a_ram_addr;
  logic        f_p0_gnt, f_p0_rvalid, f_p1_gnt, f_p1_rvalid, f_ram_ce;
  logic [31:0] f_p0_rdata, f_p1_rdata, f_ram_wdata, f_ram_rdata;
  logic [3:0]  f_ram_we;
  logic [4:0]  f_ram_addr;
`ifdef PANDA_DMEM_ARB_PERF_EN
  logic [31:0] a_c0, a_c1, a_cs, f_c0, f_c1, f_cs;
`endif

  logic [31:0] mem_a [32];
  logic [31:0] mem_f [32];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  panda_dmem_arbiter #(.DataMemDepth(32), .RoundRobin(1'b1)) u_rr (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_gnt_o(a_p0_gnt), .p0_rvalid_o(a_p0_rvalid), .p0_rdata_o(a_p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_gnt_o(a_p1_gnt), .p1_rvalid_o(a_p1_rvalid), .p1_rdata_o(a_p1_rdata),
`ifdef PANDA_DMEM_ARB_PERF_EN
    .p0_grant_cnt_o(a_c0), .p1_grant_cnt_o(a_c1), .stall_cnt_o(a_cs),
`endif
    .ram_ce_o(a_ram_ce), .ram_we_o(a_ram_we), .ram_addr_o(a_ram_addr),
    .ram_wdata_o(a_ram_wdata), .ram_rdata_i(a_ram_rdata)
  );

  panda_dmem_arbiter #(.DataMemDepth(32), .RoundRobin(1'b0)) u_fp (
    .clk_i(clk), .rst_i(rst),
    .p0_req_i(p0_req), .p0_we_i(p0_we), .p0_addr_i(p0_addr), .p0_wdata_i(p0_wdata),
    .p0_gnt_o(f_p0_gnt), .p0_rvalid_o(f_p0_rvalid), .p0_rdata_o(f_p0_rdata),
    .p1_req_i(p1_req), .p1_we_i(p1_we), .p1_addr_i(p1_addr), .p1_wdata_i(p1_wdata),
    .p1_gnt_o(f_p1_gnt), .p1_rvalid_o(f_p1_rvalid), .p1_rdata_o(f_p1_rdata),
`ifdef PANDA_DMEM_ARB_PERF_EN
    .p0_grant_cnt_o(f_c0), .p1_grant_cnt_o(f_c1), .stall_cnt_o(f_cs),
`endif
    .ram_ce_o(f_ram_ce), .ram_we_o(f_ram_we), .ram_addr_o(f_ram_addr),
    .ram_wdata_o(f_ram_wdata), .ram_rdata_i(f_ram_rdata)
  );

  // Behavioural single-port RAMs: byte writes, registered read, word i starts as 0x112233_ii.
  always_ff @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 32; i++) mem_a[i] <= 32'h1122_3300 + 32'(i);
    end else if (a_ram_ce) begin
      for (int b = 0; b < 4; b++)
        if (a_ram_we[b]) mem_a[a_ram_addr][8*b +: 8] <= a_ram_wdata[8*b +: 8];
      a_ram_rdata <= mem_a[a_ram_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 32; i++) mem_f[i] <= 32'h1122_3300 + 32'(i);
    end else if (f_ram_ce) begin
      for (int b = 0; b < 4; b++)
        if (f_ram_we[b]) mem_f[f_ram_addr][8*b +: 8] <= f_ram_wdata[8*b +: 8];
      f_ram_rdata <= mem_f[f_ram_addr];
    end
  end

  task automatic chk1(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic exp_p1;
    rst = 1'b1; ram_init = 1'b1;
    p0_req = 1'b1; p0_we = 4'h0; p0_addr = 32'h0; p0_wdata = 32'h0;
    p1_req = 1'b1; p1_we = 4'h0; p1_addr = 32'h0; p1_wdata = 32'h0;
    tick();
    ram_init = 1'b0;

    // 1. Reset with both ports requesting: nothing granted, nothing driven.
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      chk1("rst_p0_gnt", a_p0_gnt, 1'b0);
      chk1("rst_p1_gnt", a_p1_gnt, 1'b0);
      chk1("rst_ram_ce", a_ram_ce, 1'b0);
      chk1("rst_p0_rvalid", a_p0_rvalid, 1'b0);
    end
    tick();
    rst = 1'b0;
    #1;
    chk1("rel_p0_gnt", a_p0_gnt, 1'b1);
    chk1("rel_p1_gnt", a_p1_gnt, 1'b0);
    chk1("rel_ram_ce", a_ram_ce, 1'b1);

    // 2. p0 write then read of 0x10 (word 4).
    tick();
    chk1("rel_p0_rvalid", a_p0_rvalid, 1'b1);
    chk32("rel_p0_rdata", a_p0_rdata, 32'h1122_3300);
    chk1("rel_p1_rvalid", a_p1_rvalid, 1'b0);
    p1_req = 1'b0;
    p0_we = 4'hF; p0_addr = 32'h0000_0010; p0_wdata = 32'hDEAD_BEEF;
    #1;
    chk1("wr_p0_gnt", a_p0_gnt, 1'b1);
    chk32("wr_ram_we", {28'h0, a_ram_we}, 32'hF);
    chk32("wr_ram_addr", {27'h0, a_ram_addr}, 32'd4);
    chk32("wr_ram_wdata", a_ram_wdata, 32'hDEAD_BEEF);
    tick();
    chk1("wr_ack_p0_rvalid", a_p0_rvalid, 1'b1);
    p0_we = 4'h0; p0_wdata = 32'h0;
    #1;
    chk1("rd_p0_gnt", a_p0_gnt, 1'b1);
    chk32("rd_ram_we", {28'h0, a_ram_we}, 32'h0);
    tick();
    chk1("rd_p0_rvalid", a_p0_rvalid, 1'b1);
    chk32("rd_p0_rdata", a_p0_rdata, 32'hDEAD_BEEF);
    chk1("rd_p1_rvalid", a_p1_rvalid, 1'b0);
    chk32("rd_p1_rdata", a_p1_rdata, 32'h0);

    // One-cycle reset to return the round-robin pointer to port 0.
    p0_req = 1'b0; rst = 1'b1;
    #1;
    chk1("idle_ram_ce", a_ram_ce, 1'b0);
    tick();
    rst = 1'b0;

    // 3. Contention, round-robin: p0 reads word 8, p1 reads word 9.
    p0_req = 1'b1; p0_addr = 32'h0000_0020;
    p1_req = 1'b1; p1_addr = 32'h0000_0024;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin
        tick();
        exp_p1 = ((i - 1) % 2) == 1;
        chk1("rr_p0_rvalid", a_p0_rvalid, !exp_p1);
        chk1("rr_p1_rvalid", a_p1_rvalid, exp_p1);
        chk32("rr_rdata", exp_p1 ? a_p1_rdata : a_p0_rdata,
              exp_p1 ? 32'h1122_3309 : 32'h1122_3308);
      end
      #1;
      chk1("rr_p0_gnt", a_p0_gnt, (i % 2) == 0);
      chk1("rr_p1_gnt", a_p1_gnt, (i % 2) == 1);
    end
    tick();
    chk1("rr_last_p1_rvalid", a_p1_rvalid, 1'b1);
    chk32("rr_last_p1_rdata", a_p1_rdata, 32'h1122_3309);
    chk1("rr_last_p0_rvalid", a_p0_rvalid, 1'b0);

    // 4. Contention, fixed priority: p0 always wins, p1 gets in once p0 drops.
    for (int j = 0; j < 3; j++) begin
      if (j > 0) begin
        tick();
        chk1("fp_p0_rvalid", f_p0_rvalid, 1'b1);
        chk32("fp_p0_rdata", f_p0_rdata, 32'h1122_3308);
      end
      #1;
      chk1("fp_p0_gnt", f_p0_gnt, 1'b1);
      chk1("fp_p1_gnt", f_p1_gnt, 1'b0);
    end
    tick();
    p0_req = 1'b0;
    #1;
    chk1("fp_drop_p1_gnt", f_p1_gnt, 1'b1);
    chk1("fp_drop_p0_gnt", f_p0_gnt, 1'b0);

    // 5. p1 byte write to 0x84 wraps onto word 1; p0 then reads 0x4.
    tick();
    chk1("fp_p1_rvalid", f_p1_rvalid, 1'b1);
    chk32("fp_p1_rdata", f_p1_rdata, 32'h1122_3309);
    p1_we = 4'b0010; p1_addr = 32'h0000_0084; p1_wdata = 32'h0000_AB00;
    #1;
    chk1("bw_p1_gnt", a_p1_gnt, 1'b1);
    chk32("bw_ram_addr", {27'h0, a_ram_addr}, 32'd1);
    chk32("bw_ram_we", {28'h0, a_ram_we}, 32'h2);
    tick();
    chk1("bw_p1_ack", a_p1_rvalid, 1'b1);
    p1_req = 1'b0; p1_we = 4'h0;
    p0_req = 1'b1; p0_addr = 32'h0000_0004;
    #1;
    chk1("bw_rd_p0_gnt", a_p0_gnt, 1'b1);
    tick();
    chk1("bw_rd_p0_rvalid", a_p0_rvalid, 1'b1);
    chk32("bw_rd_p0_rdata", a_p0_rdata, 32'h1122_AB01);

    // 6. p0 read granted this cycle, reset next cycle kills its response.
    tick();
    rst = 1'b1; p0_addr = 32'h0000_0010;
    #1;
    chk1("mid_rst_p0_rvalid", a_p0_rvalid, 1'b0);
    chk32("mid_rst_p0_rdata", a_p0_rdata, 32'h0);
    chk1("mid_rst_p0_gnt", a_p0_gnt, 1'b0);
    chk1("mid_rst_ram_ce", a_ram_ce, 1'b0);
    chk32("mid_rst_ram_addr", {27'h0, a_ram_addr}, 32'd0);
    tick();
    chk1("post_rst_p0_rvalid", a_p0_rvalid, 1'b0);
`ifdef PANDA_DMEM_ARB_PERF_EN
    chk32("perf_a_p0_cnt", a_c0, 32'h0);
    chk32("perf_a_p1_cnt", a_c1, 32'h0);
    chk32("perf_a_stall_cnt", a_cs, 32'h0);
    chk32("perf_f_stall_cnt", f_cs, 32'h0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
